// File: rtl/sram_arb_pkg.sv
// Shared state encodings and default widths for multi_sram_arbiter and its round-robin helper.
// The optional overflow flag is enabled by defining SRAM_ARB_OVERFLOW_EN.
package sram_arb_pkg;

   localparam int unsigned DefAddrWidth   = 16;
   localparam int unsigned DefDataWidth   = 16;
   localparam int unsigned DefOutputCount = 10;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StWrite = 3'd1,
      StRead  = 3'd2,
      StWait  = 3'd3,
      StDone  = 3'd4
   } arb_state_e;

   // Index width that still works for a single channel.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches from last_grant+1 (mod N) for the first
// active request, so the channel granted last has the lowest priority.
module rr_arbiter
   import sram_arb_pkg::*;
#(
   parameter int unsigned N  = DefOutputCount,
   parameter int unsigned IW = idx_width(N)
) (
   input  logic [N-1:0]  requests,
   input  logic [IW-1:0] last_grant,
   output logic [IW-1:0] grant,
   output logic          valid
);

   localparam int unsigned IW1 = IW + 1;

   logic [IW:0] idx;

   always_comb begin
      grant = '0;
      valid = 1'b0;
      idx   = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         // last_grant + k never exceeds 2N-1, so one conditional subtract wraps it.
         idx = {1'b0, last_grant} + IW1'(k);
         if (idx >= IW1'(N)) begin
            idx = idx - IW1'(N);
         end
         if (!valid && requests[idx[IW-1:0]]) begin
            valid = 1'b1;
            grant = idx[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/multi_sram_arbiter.sv
// Shares one synchronous single-port SRAM between a write port and OUTPUT_COUNT read channels.
// Define SRAM_ARB_OVERFLOW_EN to keep the older pending write and flag a sticky write_overflow.
module multi_sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int unsigned ADDRESS_BUS_WIDTH = DefAddrWidth,
   parameter int unsigned DATA_BUS_WIDTH    = DefDataWidth,
   parameter int unsigned OUTPUT_COUNT      = DefOutputCount
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic [ADDRESS_BUS_WIDTH-1:0]              write_address,
   input  logic [DATA_BUS_WIDTH-1:0]                 write_data,
   input  logic                                      write_strobe,
   input  logic [OUTPUT_COUNT-1:0]                   read_requests,
   input  logic [OUTPUT_COUNT*ADDRESS_BUS_WIDTH-1:0] read_addresses,
   output logic [DATA_BUS_WIDTH-1:0]                 read_data,
   output logic [OUTPUT_COUNT-1:0]                   read_finished_strobes,
   output logic [ADDRESS_BUS_WIDTH-1:0]              ram_address,
   output logic [DATA_BUS_WIDTH-1:0]                 ram_write_data,
   output logic                                      ram_write_enable,
   input  logic [DATA_BUS_WIDTH-1:0]                 ram_read_data,
`ifdef SRAM_ARB_OVERFLOW_EN
   output logic                                      write_overflow,
`endif
   output logic [2:0]                                state
);

   localparam int unsigned IW = idx_width(OUTPUT_COUNT);

   arb_state_e                   state_q, state_d;
   logic                         pend_valid_q, pend_valid_d;
   logic [ADDRESS_BUS_WIDTH-1:0] pend_addr_q, pend_addr_d;
   logic [DATA_BUS_WIDTH-1:0]    pend_data_q, pend_data_d;
   logic [IW-1:0]                last_grant_q, last_grant_d;
   logic [IW-1:0]                grant_q, grant_d;
   logic [ADDRESS_BUS_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic [DATA_BUS_WIDTH-1:0]    read_data_q, read_data_d;
   logic [OUTPUT_COUNT-1:0]      strobe_q, strobe_d;
`ifdef SRAM_ARB_OVERFLOW_EN
   logic                         ovf_q, ovf_d;
`endif

   logic [IW-1:0]                rr_grant;
   logic                         rr_valid;
   logic                         retire;
   logic                         take;
   logic [ADDRESS_BUS_WIDTH-1:0] chan_addr [OUTPUT_COUNT];

   for (genvar i = 0; i < OUTPUT_COUNT; i++) begin : g_chan_addr
      assign chan_addr[i] = read_addresses[i*ADDRESS_BUS_WIDTH +: ADDRESS_BUS_WIDTH];
   end

   rr_arbiter #(
      .N  (OUTPUT_COUNT),
      .IW (IW)
   ) u_rr_arbiter (
      .requests   (read_requests),
      .last_grant (last_grant_q),
      .grant      (rr_grant),
      .valid      (rr_valid)
   );

   always_comb begin
      state_d      = state_q;
      pend_valid_d = pend_valid_q;
      pend_addr_d  = pend_addr_q;
      pend_data_d  = pend_data_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      rd_addr_d    = rd_addr_q;
      read_data_d  = read_data_q;
      strobe_d     = '0;

      // The pending slot frees up at the end of WRITE, so a strobe in that cycle refills it.
      retire = (state_q == StWrite);
      if (retire) begin
         pend_valid_d = 1'b0;
      end
`ifdef SRAM_ARB_OVERFLOW_EN
      take  = write_strobe && (!pend_valid_q || retire);
      ovf_d = ovf_q | (write_strobe && !take);
`else
      take  = write_strobe;
`endif
      if (take) begin
         pend_valid_d = 1'b1;
         pend_addr_d  = write_address;
         pend_data_d  = write_data;
      end

      case (state_q)
         StIdle: begin
            if (pend_valid_q) begin
               state_d = StWrite;
            end else if (rr_valid) begin
               grant_d      = rr_grant;
               last_grant_d = rr_grant;
               rd_addr_d    = chan_addr[rr_grant];
               state_d      = StRead;
            end
         end
         StWrite: state_d = StIdle;
         StRead:  state_d = StWait;
         StWait:  state_d = StDone;
         StDone: begin
            read_data_d        = ram_read_data;
            strobe_d[grant_q]  = 1'b1;
            state_d            = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         pend_valid_q <= 1'b0;
         pend_addr_q  <= '0;
         pend_data_q  <= '0;
         last_grant_q <= IW'(OUTPUT_COUNT - 1);
         grant_q      <= '0;
         rd_addr_q    <= '0;
         read_data_q  <= '0;
         strobe_q     <= '0;
`ifdef SRAM_ARB_OVERFLOW_EN
         ovf_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         pend_valid_q <= pend_valid_d;
         pend_addr_q  <= pend_addr_d;
         pend_data_q  <= pend_data_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         rd_addr_q    <= rd_addr_d;
         read_data_q  <= read_data_d;
         strobe_q     <= strobe_d;
`ifdef SRAM_ARB_OVERFLOW_EN
         ovf_q        <= ovf_d;
`endif
      end
   end

   assign ram_write_enable      = (state_q == StWrite);
   assign ram_address           = (state_q == StWrite) ? pend_addr_q : rd_addr_q;
   assign ram_write_data        = pend_data_q;
   assign read_data             = read_data_q;
   assign read_finished_strobes = strobe_q;
   assign state                 = state_q;
`ifdef SRAM_ARB_OVERFLOW_EN
   assign write_overflow        = ovf_q;
`endif

endmodule
